// File: rtl/arm_cortex_m0p_pkg.sv
// Shared types for the multicycle controller: FSM states, opcodes, ALU selects
// and branch condition codes, plus an opcode-membership helper.
package arm_cortex_m0p_pkg;

    localparam int DATA_WIDTH = 16;

    // state    | meaning
    // FETCH    | latch instr into ir, advance PC by one
    // DECODE   | classify ir opcode, trap on undefined encodings
    // EXEC     | drive ALU select, latch flags (CMP), resolve branches
    // MEM      | hold data-memory strobe until dm_ready
    // WB       | one-cycle register-file write
    // TRAP     | undefined opcode seen; parked until reset
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_t;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_AND    = 4'h2,
        OP_OR     = 4'h3,
        OP_CMP    = 4'h4,
        OP_LDR    = 4'h5,
        OP_STR    = 4'h6,
        OP_BRANCH = 4'h8
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        BR_EQ = 4'h0,
        BR_MI = 4'h1,
        BR_AL = 4'h2
    } branch_t;

    // True when the 4-bit field encodes a defined opcode.
    function automatic logic is_opcode(input logic [3:0] code);
        logic ok;
        case (code)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_CMP, OP_LDR, OP_STR, OP_BRANCH: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle instruction controller. Outputs depend only on the
// registered state, ir and flags; strobes are additionally forced low while
// rst is high so a pending memory access is dropped without waiting for a clock.
module multicycle_ctrl
    import arm_cortex_m0p_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        dm_ready,
    output logic [15:0] ir,
    output logic        pc_en,
    output logic        pc_src,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        dm_re,
    output logic        dm_we,
    output logic [2:0]  state,
    output logic        illegal
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        flag_z;
    logic        flag_n;
    logic        br_taken;
    logic [3:0]  opcode;
    logic [3:0]  br_code;

    assign opcode  = ir[15:12];
    assign br_code = ir[11:8];
    assign state   = state_q;

    // State register, instruction register and CMP flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir      <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH) begin
                ir <= instr;
            end
            if (state_q == ST_EXEC && opcode == OP_CMP) begin
                flag_z <= alu_z;
                flag_n <= alu_n;
            end
        end
    end

    // Next-state selection and all state-decoded outputs.
    always_comb begin
        state_d  = state_q;
        pc_en    = 1'b0;
        pc_src   = 1'b0;
        alu_op   = ALU_ADD;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        illegal  = 1'b0;
        br_taken = 1'b0;

        case (state_q)
            ST_FETCH: begin
                pc_en   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = is_opcode(opcode) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_SUB, OP_CMP: alu_op = ALU_SUB;
                    OP_AND:         alu_op = ALU_AND;
                    OP_OR:          alu_op = ALU_OR;
                    default:        alu_op = ALU_ADD;
                endcase
                case (opcode)
                    OP_CMP, OP_BRANCH: state_d = ST_FETCH;
                    OP_LDR, OP_STR:    state_d = ST_MEM;
                    default:           state_d = ST_WB;
                endcase
                if (opcode == OP_BRANCH) begin
                    case (br_code)
                        BR_EQ:   br_taken = flag_z;
                        BR_MI:   br_taken = flag_n;
                        BR_AL:   br_taken = 1'b1;
                        default: br_taken = 1'b0;
                    endcase
                    pc_en  = br_taken;
                    pc_src = br_taken;
                end
            end
            ST_MEM: begin
                dm_re = (opcode == OP_LDR);
                dm_we = (opcode == OP_STR);
                if (dm_ready) begin
                    state_d = (opcode == OP_LDR) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                wb_sel  = (opcode == OP_LDR);
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Strobes must fall with rst itself, not at the next edge.
        if (rst) begin
            pc_en  = 1'b0;
            pc_src = 1'b0;
            rf_we  = 1'b0;
            dm_re  = 1'b0;
            dm_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: per-cycle stimulus and the
// expected output vector are queued together, then replayed cycle by cycle.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        alu_z;
    logic        alu_n;
    logic        dm_ready;
    logic [15:0] ir;
    logic        pc_en;
    logic        pc_src;
    logic [1:0]  alu_op;
    logic        rf_we;
    logic        wb_sel;
    logic        dm_re;
    logic        dm_we;
    logic [2:0]  state;
    logic        illegal;

    multicycle_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .alu_z    (alu_z),
        .alu_n    (alu_n),
        .dm_ready (dm_ready),
        .ir       (ir),
        .pc_en    (pc_en),
        .pc_src   (pc_src),
        .alu_op   (alu_op),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .state    (state),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_T = 3'd5;

    typedef struct {
        string       tag;
        logic [15:0] instr;
        logic        z;
        logic        n;
        logic        rdy;
        logic [11:0] exp_v;
        logic [15:0] exp_ir;
    } step_t;

    step_t       sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] cur_ir   = 16'h0000;
    logic [11:0] obs_v;

    assign obs_v = {state, pc_en, pc_src, alu_op, rf_we, wb_sel, dm_re, dm_we, illegal};

    function automatic logic [11:0] mk(logic [2:0] s, logic pe, logic ps, logic [1:0] ao,
                                       logic we, logic ws, logic re, logic dw, logic il);
        return {s, pe, ps, ao, we, ws, re, dw, il};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic [15:0] r16();
        return 16'($urandom);
    endfunction

    task automatic chk12(string tag, logic [11:0] obs, logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [15:0] i, logic z, logic n, logic rdy, logic [11:0] v);
        step_t e;
        e.tag    = tag;
        e.instr  = i;
        e.z      = z;
        e.n      = n;
        e.rdy    = rdy;
        e.exp_v  = v;
        e.exp_ir = cur_ir;
        sb.push_back(e);
    endtask

    task automatic fetch_decode(string tag, logic [15:0] i);
        push({tag, "_F"}, i, rb(), rb(), rb(), mk(S_F, 1, 0, 2'b00, 0, 0, 0, 0, 0));
        cur_ir = i;
        push({tag, "_D"}, r16(), rb(), rb(), rb(), mk(S_D, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    endtask

    task automatic alu_instr(string tag, logic [15:0] i, logic [1:0] ao, logic n);
        fetch_decode(tag, i);
        push({tag, "_E"}, r16(), ~n, n, rb(), mk(S_E, 0, 0, ao, 0, 0, 0, 0, 0));
        push({tag, "_W"}, r16(), rb(), rb(), rb(), mk(S_W, 0, 0, 2'b00, 1, 0, 0, 0, 0));
    endtask

    task automatic cmp_instr(string tag, logic [15:0] i, logic z, logic n);
        fetch_decode(tag, i);
        push({tag, "_E"}, r16(), z, n, rb(), mk(S_E, 0, 0, 2'b01, 0, 0, 0, 0, 0));
    endtask

    task automatic br_instr(string tag, logic [15:0] i, logic taken);
        fetch_decode(tag, i);
        push({tag, "_E"}, r16(), rb(), rb(), rb(), mk(S_E, taken, taken, 2'b00, 0, 0, 0, 0, 0));
    endtask

    task automatic ldr_instr(string tag, logic [15:0] i, int w);
        fetch_decode(tag, i);
        push({tag, "_E"}, r16(), rb(), rb(), rb(), mk(S_E, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        for (int k = 0; k < w; k++)
            push({tag, "_Mw"}, r16(), rb(), rb(), 1'b0, mk(S_M, 0, 0, 2'b00, 0, 0, 1, 0, 0));
        push({tag, "_M"}, r16(), rb(), rb(), 1'b1, mk(S_M, 0, 0, 2'b00, 0, 0, 1, 0, 0));
        push({tag, "_W"}, r16(), rb(), rb(), rb(), mk(S_W, 0, 0, 2'b00, 1, 1, 0, 0, 0));
    endtask

    task automatic str_instr(string tag, logic [15:0] i, int w, bit finish);
        fetch_decode(tag, i);
        push({tag, "_E"}, r16(), rb(), rb(), rb(), mk(S_E, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        for (int k = 0; k < w; k++)
            push({tag, "_Mw"}, r16(), rb(), rb(), 1'b0, mk(S_M, 0, 0, 2'b00, 0, 0, 0, 1, 0));
        if (finish)
            push({tag, "_M"}, r16(), rb(), rb(), 1'b1, mk(S_M, 0, 0, 2'b00, 0, 0, 0, 1, 0));
    endtask

    task automatic trap_instr(string tag, logic [15:0] i, int hold);
        fetch_decode(tag, i);
        for (int k = 0; k < hold; k++)
            push({tag, "_T"}, r16(), rb(), rb(), rb(), mk(S_T, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    endtask

    // Replays the queue; must be entered on a falling edge.
    task automatic drain();
        step_t e;
        while (sb.size() > 0) begin
            e        = sb.pop_front();
            instr    = e.instr;
            alu_z    = e.z;
            alu_n    = e.n;
            dm_ready = e.rdy;
            #1;
            chk12(e.tag, obs_v, e.exp_v);
            chk16({e.tag, "_ir"}, ir, e.exp_ir);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk12({tag, "_outs"}, obs_v, mk(S_F, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        chk16({tag, "_ir"}, ir, 16'h0000);
        @(negedge clk);
        rst    = 1'b0;
        cur_ir = 16'h0000;
    endtask

    initial begin
        rst      = 1'b1;
        instr    = 16'h0000;
        alu_z    = 1'b0;
        alu_n    = 1'b0;
        dm_ready = 1'b0;
        do_reset("reset0");

        alu_instr("add", 16'h0123, 2'b00, 1'b1);
        br_instr("bmi_after_add", 16'h8105, 1'b0);
        cmp_instr("cmp_z1", 16'h4012, 1'b1, 1'b0);
        br_instr("beq_taken", 16'h8005, 1'b1);
        cmp_instr("cmp_z0", 16'h4012, 1'b0, 1'b0);
        br_instr("beq_not", 16'h8005, 1'b0);
        cmp_instr("cmp_n1", 16'h4034, 1'b0, 1'b1);
        br_instr("bmi_taken", 16'h8107, 1'b1);
        br_instr("b_always", 16'h8200, 1'b1);
        br_instr("br_undef", 16'h8300, 1'b0);
        br_instr("beq_z0", 16'h8000, 1'b0);
        alu_instr("sub", 16'h1456, 2'b01, 1'b0);
        alu_instr("and", 16'h2789, 2'b10, 1'b0);
        alu_instr("or", 16'h3abc, 2'b11, 1'b0);
        br_instr("bmi_kept", 16'h8100, 1'b1);
        ldr_instr("ldr_w3", 16'h5123, 3);
        ldr_instr("ldr_w0", 16'h5000, 0);
        str_instr("str_w1", 16'h6111, 1, 1'b1);
        str_instr("str_w0", 16'h6000, 0, 1'b1);
        drain();

        cmp_instr("cmp_z1n1", 16'h4055, 1'b1, 1'b1);
        str_instr("str_rst", 16'h6222, 2, 1'b0);
        drain();
        dm_ready = 1'b0;
        #1;
        chk12("str_rst_wait", obs_v, mk(S_M, 0, 0, 2'b00, 0, 0, 0, 1, 0));
        #2;
        rst = 1'b1;
        #1;
        chk12("str_rst_async", obs_v, mk(S_F, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        chk16("str_rst_ir", ir, 16'h0000);
        @(negedge clk);
        rst    = 1'b0;
        cur_ir = 16'h0000;

        br_instr("beq_flags_clr", 16'h8005, 1'b0);
        br_instr("bmi_flags_clr", 16'h8100, 1'b0);
        trap_instr("trap_f", 16'hF000, 21);
        drain();
        do_reset("reset_trap");

        trap_instr("trap_9", 16'h9000, 3);
        drain();
        do_reset("reset_trap9");

        alu_instr("add_after", 16'h0001, 2'b00, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL declare: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL declare: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL declare: instr  in  16  instruction word from instruction memory; valid during FETCH.
REQ-004 SHALL declare: alu_z  in  1  ALU result-zero flag; valid during EXEC.
REQ-005 SHALL declare: alu_n  in  1  ALU result-negative flag (bit DATA_WIDTH-1); valid during EXEC.
REQ-006 SHALL declare: dm_ready  in  1  data memory completes the access this cycle.
REQ-007 SHALL declare: ir  out  16  latched instruction register.
REQ-008 SHALL declare: pc_en  out  1  PC update strobe.
REQ-009 SHALL declare: pc_src  out  1  0 = PC+1, 1 = branch target.
REQ-010 SHALL declare: alu_op  out  2  alu_op_t select for the datapath ALU.
REQ-011 SHALL declare: rf_we  out  1  register-file write enable.
REQ-012 SHALL declare: wb_sel  out  1  0 = ALU result, 1 = memory data.
REQ-013 SHALL declare: dm_re / dm_we  out  1 each  data memory read and write strobes.
REQ-014 SHALL declare: state  out  3  current FSM state, for debug.
REQ-015 SHALL declare: illegal  out  1  undefined opcode trapped.

Function
REQ-016 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-017 SHALL behave in FETCH as follows: ir<=instr; pc_en=1, pc_src=0; next state DECODE.
REQ-018 SHALL behave in DECODE as follows: next state TRAP if ir[15:12] is not an opcode_t member, else EXEC.
REQ-019 SHALL behave in EXEC as follows: alu_op = ADD for ADD/LDR/STR, SUB for SUB/CMP, AND for AND, OR for OR.
REQ-020 SHALL, on CMP in EXEC, latch alu_z and alu_n into internal flags Z,N and go next to FETCH.
REQ-021 SHALL latch flags only on CMP; ADD/SUB/AND/OR SHALL leave flags unchanged.
REQ-022 SHALL, on BRANCH in EXEC, evaluate ir[11:8] as branch_t: BEQ taken iff Z=1, BMI taken iff N=1, B always taken, any other code not taken.
REQ-023 SHALL, on a taken branch, drive pc_en=1 and pc_src=1 for one cycle; next state FETCH either way.
REQ-024 SHALL route ADD/SUB/AND/OR from EXEC to WB, and LDR/STR from EXEC to MEM.
REQ-025 SHALL, in MEM, hold dm_re=1 (LDR) or dm_we=1 (STR) until dm_ready=1, with no timeout.
REQ-026 SHALL, on dm_ready=1 in MEM, go to WB for LDR and to FETCH for STR.
REQ-027 SHALL, in WB, drive rf_we=1 for one cycle, with wb_sel=1 for LDR and 0 otherwise; next state FETCH.
REQ-028 SHALL, in TRAP, drive illegal=1 with all strobes 0, and hold TRAP until rst.
REQ-029 SHALL keep pc_en, rf_we, dm_re and dm_we 0 in every state/condition not listed above; strobes SHALL never overlap.
REQ-030 SHALL meet these latencies in cycles: ALU op 4; CMP 3; BRANCH 3; STR 4+w; LDR 5+w, where w = dm_ready wait cycles.

Reset
REQ-031 SHALL, on rst asserted, immediately force state=FETCH, ir=0, Z=N=0, illegal=0 and all strobes 0.
REQ-032 SHALL, on rst asserted mid-MEM, abort the pending access, deasserting dm_re/dm_we asynchronously.
REQ-033 SHALL, after rst deasserts, perform the first FETCH at the next rising edge.

Structure
REQ-034 SHALL place the state enum ctrl_state_t in arm_cortex_m0p_pkg, alongside opcode_t, alu_op_t, branch_t and DATA_WIDTH.
REQ-035 SHALL split into two always blocks: sequential state/IR/flags, and combinational next-state plus outputs.
REQ-036 SHALL be a single module with no sub-module.

Verification
REQ-037 SHALL cover: instr=0x0123 (ADD r1,r2,r3) -> states F,D,E,WB; rf_we=1 only in cycle 4; alu_op=00; wb_sel=0.
REQ-038 SHALL cover: CMP with alu_z=1, then instr=0x8005 (BEQ) -> pc_src=1 and pc_en=1 in cycle 3; repeat with alu_z=0 -> no branch.
REQ-039 SHALL cover: LDR with dm_ready low 3 cycles -> dm_re high 4 cycles, then WB with rf_we=1, wb_sel=1; total 8 cycles.
REQ-040 SHALL cover: instr=0xF000 -> TRAP in cycle 3, illegal=1 held 20 cycles; rst -> FETCH, illegal=0.
REQ-041 SHALL cover: rst asserted mid-STR wait -> dm_we drops within the same cycle, state=FETCH.
REQ-042 SHALL cover: ADD setting alu_n=1 followed by BMI -> not taken, since flags are unchanged.
